// File: rtl/vr_pass_ctrl.sv
// vr_pass_ctrl -- pass sequencer for the sparse vector-reduction loop.
// Monitors the upstream coordinate stream and the write-scanner input stream
// and drives the shared read-scanner us_pos_in stream, one loopback pass at a
// time. A loopback read of pass k is only issued once pass k-1 has been fully
// written back. After the upstream DONE token the final read-out is issued
// with final_sel asserted.
// Build option: define VR_PASS_CTRL_PERF_EN to enable the stall_cnt counter;
// without it stall_cnt is tied to zero.

module vr_pass_ctrl #(
    parameter int SLOTS = 256,  // buffet fiber slots, power of 2, at most 65536
    parameter int CNT_W = 16    // pass / write counter width
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_en,
    input  logic             flush,
    input  logic             tile_en,
    input  logic [16:0]      up_data,
    input  logic             up_valid,
    input  logic             up_ready,
    input  logic [16:0]      wr_data,
    input  logic             wr_valid,
    input  logic             wr_ready,
    output logic [16:0]      pos_out,
    output logic             pos_out_valid,
    input  logic             pos_out_ready,
    output logic             final_sel,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [31:0]      stall_cnt
);

    localparam logic [16:0] S0_TOK   = 17'h10000;
    localparam logic [16:0] DONE_TOK = 17'h10100;
    localparam logic [15:0] POS_MASK = 16'(SLOTS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECIDE,
        ST_POS,
        ST_STOP,
        ST_FIN_POS,
        ST_FIN_STOP,
        ST_FIN_DONE,
        ST_END
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wr_cnt;
    logic [CNT_W-1:0] p_next;
    logic [CNT_W-1:0] p_minus1;
    logic [16:0]      pos_next;
    logic             wr_s0;
    logic             write_done;

    // The upstream handshake is observed only; the sequencer never consumes it.
    logic unused_up_ready;
    assign unused_up_ready = up_ready;

    // A write-scanner S0 marks one pass fully written back.
    assign wr_s0 = wr_valid & wr_ready & (wr_data == S0_TOK);

    // Previous pass fully written: equality only, so counter wrap is harmless.
    assign write_done = (wr_cnt == pass_cnt);

    // Pass count after this edge (saturation bound for wr_cnt) and the
    // loopback read position of the pass about to be issued.
    always_comb begin
        // NOTE: every always_comb output is given a default first, so no path
        // leaves it unassigned and no latch is inferred.
        p_next = pass_cnt;
        if (state == ST_STOP && pos_out_ready) begin
            p_next = pass_cnt + CNT_W'(1);
        end
        p_minus1 = pass_cnt - CNT_W'(1);
        pos_next = {1'b0, 16'(p_minus1) & POS_MASK};
    end

    // Pass FSM with registered pos_out / valid / final_sel and the counters.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state         <= ST_IDLE;
            pos_out       <= '0;
            pos_out_valid <= 1'b0;
            final_sel     <= 1'b0;
            pass_cnt      <= '0;
            wr_cnt        <= '0;
        end else if (flush) begin
            // Flush wins over everything, including a handshake in flight.
            state         <= ST_IDLE;
            pos_out       <= '0;
            pos_out_valid <= 1'b0;
            final_sel     <= 1'b0;
            pass_cnt      <= '0;
            wr_cnt        <= '0;
        end else if (clk_en) begin
            // Write-back counter never runs ahead of the passes issued.
            if (wr_s0 && (wr_cnt != p_next)) begin
                wr_cnt <= wr_cnt + CNT_W'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (tile_en) begin
                        state <= ST_DECIDE;
                    end
                end

                ST_DECIDE: begin
                    if (up_valid && write_done) begin
                        pos_out_valid <= 1'b1;
                        if (up_data == DONE_TOK) begin
                            final_sel <= 1'b1;
                            if (pass_cnt == '0) begin
                                state   <= ST_FIN_DONE;
                                pos_out <= DONE_TOK;
                            end else begin
                                state   <= ST_FIN_POS;
                                pos_out <= pos_next;
                            end
                        end else if (pass_cnt == '0) begin
                            // Pass 0 reads an empty fiber: S0 only.
                            state   <= ST_STOP;
                            pos_out <= S0_TOK;
                        end else begin
                            state   <= ST_POS;
                            pos_out <= pos_next;
                        end
                    end
                end

                ST_POS: begin
                    if (pos_out_ready) begin
                        state   <= ST_STOP;
                        pos_out <= S0_TOK;
                    end
                end

                ST_STOP: begin
                    if (pos_out_ready) begin
                        state         <= ST_DECIDE;
                        pos_out_valid <= 1'b0;
                        pass_cnt      <= pass_cnt + CNT_W'(1);
                    end
                end

                ST_FIN_POS: begin
                    if (pos_out_ready) begin
                        state   <= ST_FIN_STOP;
                        pos_out <= S0_TOK;
                    end
                end

                ST_FIN_STOP: begin
                    if (pos_out_ready) begin
                        state   <= ST_FIN_DONE;
                        pos_out <= DONE_TOK;
                    end
                end

                ST_FIN_DONE: begin
                    if (pos_out_ready) begin
                        state         <= ST_END;
                        pos_out_valid <= 1'b0;
                    end
                end

                ST_END: begin
                    // Parked until flush; tile_en is not looked at here.
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef VR_PASS_CTRL_PERF_EN
    // Count DECIDE cycles blocked on write-back while upstream has a token.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (flush) begin
            stall_cnt <= '0;
        end else if (clk_en && (state == ST_DECIDE) && up_valid && !write_done
                     && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_vr_pass_ctrl.sv
// Testbench for vr_pass_ctrl. Two instances share all inputs: SLOTS=256 and
// SLOTS=4 (position wrap). A job table drives whole loops; a queue-based
// model derived from the pass rules supplies the expected token stream.
`timescale 1ns/1ps

module tb_vr_pass_ctrl;

    localparam logic [16:0] S0_TOK   = 17'h10000;
    localparam logic [16:0] DONE_TOK = 17'h10100;
    localparam int          CNT_W    = 16;
    localparam int          BUDGET   = 4000;
`ifdef VR_PASS_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n, clk_en, flush, tile_en;
    logic [16:0]      up_data, wr_data;
    logic             up_valid, up_ready, wr_valid, wr_ready, pos_out_ready;
    logic [16:0]      pos_out_a, pos_out_b;
    logic             pos_out_valid_a, pos_out_valid_b;
    logic             final_sel_a, final_sel_b;
    logic [CNT_W-1:0] pass_cnt_a, pass_cnt_b;
    logic [31:0]      stall_cnt_a, stall_cnt_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vr_pass_ctrl #(.SLOTS(256), .CNT_W(CNT_W)) dut_a (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush), .tile_en(tile_en),
        .up_data(up_data), .up_valid(up_valid), .up_ready(up_ready),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .pos_out(pos_out_a), .pos_out_valid(pos_out_valid_a), .pos_out_ready(pos_out_ready),
        .final_sel(final_sel_a), .pass_cnt(pass_cnt_a), .stall_cnt(stall_cnt_a)
    );

    vr_pass_ctrl #(.SLOTS(4), .CNT_W(CNT_W)) dut_b (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush), .tile_en(tile_en),
        .up_data(up_data), .up_valid(up_valid), .up_ready(up_ready),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .pos_out(pos_out_b), .pos_out_valid(pos_out_valid_b), .pos_out_ready(pos_out_ready),
        .final_sel(final_sel_b), .pass_cnt(pass_cnt_b), .stall_cnt(stall_cnt_b)
    );

    // One loop run: stimulus knobs plus the outcome expected from them.
    typedef struct {
        int n_fibers;       // non-DONE upstream fibers before DONE
        int wr_delay;       // edges from pass S0 accept to its write-back S0
        bit rand_mode;      // random ready/clk_en/up_valid/tile_en/noise
        int exp_pass;       // pass_cnt at the end
        int exp_done_edge;  // edge on which DONE is accepted (0 = not checked)
        int exp_stall;      // stall_cnt at the end with the perf counter
    } job_t;

    // Expected accepted token on pos_out for both instances.
    typedef struct {
        logic [16:0] tok_a;
        logic [16:0] tok_b;
        bit          fin;
        bit          reg_s0;
    } tok_t;

    tok_t exp_q[$];
    job_t jobs[9];

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [16:0] pos_tok(input int k, input int slots);
        return {1'b0, 16'(k % slots)};
    endfunction

    // Token stream from the pass rules: pass k reads slot k-1 (none for k=0),
    // then S0; the final read-out reads the last slot, S0, DONE.
    task automatic build_expected(input int n);
        tok_t e;
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            if (k > 0) begin
                e = '{pos_tok(k - 1, 256), pos_tok(k - 1, 4), 1'b0, 1'b0};
                exp_q.push_back(e);
            end
            e = '{S0_TOK, S0_TOK, 1'b0, 1'b1};
            exp_q.push_back(e);
        end
        if (n > 0) begin
            e = '{pos_tok(n - 1, 256), pos_tok(n - 1, 4), 1'b1, 1'b0};
            exp_q.push_back(e);
            e = '{S0_TOK, S0_TOK, 1'b1, 1'b0};
            exp_q.push_back(e);
        end
        e = '{DONE_TOK, DONE_TOK, 1'b1, 1'b0};
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; clk_en = 1'b1; flush = 1'b0; tile_en = 1'b0;
        up_data = '0; up_valid = 1'b0; up_ready = 1'b0;
        wr_data = '0; wr_valid = 1'b0; wr_ready = 1'b0; pos_out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Runs one job from IDLE, acting as upstream, write scanner and consumer.
    task automatic run_job(input job_t j);
        int          issued = 0;
        int          counted = 0;
        int          cyc = 0;
        int          done_edge = 0;
        logic [31:0] stall_exp = '0;
        int          due_q[$];
        bit          hold_pending = 1'b0;
        logic [16:0] held_tok = '0;
        bit          seen_hs = 1'b0;
        bit          hs, wr_ev;
        tok_t        e;

        build_expected(j.n_fibers);
        tile_en = 1'b1;
        flush   = 1'b0;
        while (!(exp_q.size() == 0 && done_edge != 0) && cyc < BUDGET) begin
            // Outputs as left by the previous edge.
            if (hold_pending) begin
                check("hold_valid", 32'(pos_out_valid_a), 32'd1);
                check("hold_token", 32'(pos_out_a), 32'(held_tok));
            end
            if (counted != issued) begin
                check("no_read_before_writeback", 32'(pos_out_valid_a), 32'd0);
            end
            check("pass_cnt", 32'(pass_cnt_a), 32'(issued));
            check("pass_cnt_slots4", 32'(pass_cnt_b), 32'(issued));
            check("stall_cnt", stall_cnt_a, stall_exp);

            // Inputs for the next edge.
            if (j.rand_mode) begin
                clk_en        = ($urandom_range(0, 9) != 0);
                pos_out_ready = 1'($urandom_range(0, 1));
                up_valid      = ($urandom_range(0, 3) != 0);
                up_ready      = 1'($urandom_range(0, 1));
                wr_ready      = ($urandom_range(0, 3) != 0);
                if (seen_hs) tile_en = 1'($urandom_range(0, 1));
            end else begin
                clk_en = 1'b1; pos_out_ready = 1'b1; up_valid = 1'b1;
                up_ready = 1'b1; wr_ready = 1'b1;
            end
            if (issued < j.n_fibers)
                up_data = ($urandom_range(0, 3) == 0) ? S0_TOK : {1'b0, 16'($urandom)};
            else
                up_data = DONE_TOK;
            if (due_q.size() > 0 && cyc + 1 >= due_q[0]) begin
                wr_valid = 1'b1; wr_data = S0_TOK;
            end else if (j.rand_mode && $urandom_range(0, 1) == 1) begin
                wr_valid = 1'b1;
                wr_data  = ($urandom_range(0, 4) == 0) ? DONE_TOK : {1'b0, 16'($urandom)};
            end else begin
                wr_valid = 1'b0; wr_data = '0;
            end

            // Model of what this edge does.
            if (PERF && clk_en && up_valid && counted != issued && stall_exp != 32'hFFFF_FFFF)
                stall_exp = stall_exp + 32'd1;
            hs    = pos_out_valid_a && pos_out_ready && clk_en;
            wr_ev = wr_valid && wr_ready && clk_en && (wr_data == S0_TOK);
            if (hs) begin
                seen_hs = 1'b1;
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL extra_token: got 0x%0h accepted, expected no token", pos_out_a);
                end else begin
                    e = exp_q.pop_front();
                    check("token", 32'(pos_out_a), 32'(e.tok_a));
                    check("final_sel", 32'(final_sel_a), 32'(e.fin));
                    check("token_slots4_valid", 32'(pos_out_valid_b), 32'd1);
                    check("token_slots4", 32'(pos_out_b), 32'(e.tok_b));
                    if (e.reg_s0) begin
                        issued++;
                        due_q.push_back(cyc + 1 + j.wr_delay);
                    end
                    if (e.tok_a == DONE_TOK) done_edge = cyc + 1;
                end
            end
            if (wr_ev) begin
                counted++;
                if (due_q.size() > 0) void'(due_q.pop_front());
            end
            hold_pending = pos_out_valid_a && !hs;
            held_tok     = pos_out_a;
            tick();
            cyc++;
        end
        if (exp_q.size() != 0 || done_edge == 0) begin
            checks++; failures++;
            $display("FAIL budget: %0d tokens still expected after %0d cycles, expected 0", exp_q.size(), cyc);
        end

        // Parked in END: nothing more issued, final routing held.
        clk_en = 1'b1; pos_out_ready = 1'b1; tile_en = 1'b1; wr_valid = 1'b0; up_valid = 1'b1;
        repeat (2) tick();
        check("end_valid", 32'(pos_out_valid_a), 32'd0);
        check("end_final_sel", 32'(final_sel_a), 32'd1);
        check("end_pass_cnt", 32'(pass_cnt_a), 32'(j.exp_pass));
        check("end_stall_cnt", stall_cnt_a, stall_exp);
        if (!j.rand_mode) begin
            check("done_edge", 32'(done_edge), 32'(j.exp_done_edge));
            check("stall_total", stall_cnt_a, PERF ? 32'(j.exp_stall) : 32'd0);
        end
    endtask

    initial begin
        //          fibers delay rand pass done stall
        jobs[0] = '{0,     1,    1'b0, 0,  3,   0};   // DONE immediately
        jobs[1] = '{3,     1,    1'b0, 3,  16,  3};   // three fibers, ready=1
        jobs[2] = '{1,     20,   1'b0, 1,  27,  20};  // write-back delayed 20
        jobs[3] = '{2,     20,   1'b0, 2,  50,  40};
        jobs[4] = '{6,     1,    1'b0, 6,  28,  6};   // slot wrap on SLOTS=4
        jobs[5] = '{3,     1,    1'b1, 3,  0,   0};   // random ready/clk_en
        jobs[6] = '{6,     2,    1'b1, 6,  0,   0};
        jobs[7] = '{12,    3,    1'b1, 12, 0,   0};
        jobs[8] = '{5,     5,    1'b1, 5,  0,   0};

        // Reset values.
        do_reset();
        check("rst_valid", 32'(pos_out_valid_a), 32'd0);
        check("rst_pos_out", 32'(pos_out_a), 32'd0);
        check("rst_final_sel", 32'(final_sel_a), 32'd0);
        check("rst_pass_cnt", 32'(pass_cnt_a), 32'd0);
        check("rst_stall_cnt", stall_cnt_a, 32'd0);

        // tile_en low holds IDLE; then DONE at once -> DONE only, final_sel at cycle 2.
        up_data = DONE_TOK; up_valid = 1'b1; pos_out_ready = 1'b1; up_ready = 1'b1;
        repeat (3) tick();
        check("idle_hold_valid", 32'(pos_out_valid_a), 32'd0);
        tile_en = 1'b1;
        tick();
        check("c1_valid", 32'(pos_out_valid_a), 32'd0);
        check("c1_final_sel", 32'(final_sel_a), 32'd0);
        tile_en = 1'b0;
        tick();
        check("c2_valid", 32'(pos_out_valid_a), 32'd1);
        check("c2_final_sel", 32'(final_sel_a), 32'd1);
        check("c2_token", 32'(pos_out_a), 32'(DONE_TOK));
        tick();
        check("c3_valid", 32'(pos_out_valid_a), 32'd0);
        check("c3_final_sel", 32'(final_sel_a), 32'd1);
        check("c3_pass_cnt", 32'(pass_cnt_a), 32'd0);
        tick();
        check("end_parked_valid", 32'(pos_out_valid_a), 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_end_final_sel", 32'(final_sel_a), 32'd0);
        check("flush_end_valid", 32'(pos_out_valid_a), 32'd0);

        // Async reset in the middle of a pass with a token pending.
        do_reset();
        tile_en = 1'b1; up_data = 17'h00005; up_valid = 1'b1; pos_out_ready = 1'b0;
        repeat (3) tick();
        check("pre_rst_valid", 32'(pos_out_valid_a), 32'd1);
        check("pre_rst_token", 32'(pos_out_a), 32'(S0_TOK));
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(pos_out_valid_a), 32'd0);
        check("async_rst_token", 32'(pos_out_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Flush in POS with a handshake in flight, then a clean re-run.
        do_reset();
        tile_en = 1'b1; up_data = 17'h00042; up_valid = 1'b1; up_ready = 1'b1;
        pos_out_ready = 1'b1; wr_ready = 1'b1;
        repeat (3) tick();                // IDLE->DECIDE->STOP->pass 0 accepted
        wr_valid = 1'b1; wr_data = S0_TOK;
        tick();                           // write-back counted, DECIDE stalls
        wr_valid = 1'b0; wr_data = '0;
        tick();                           // DECIDE -> POS
        check("pos_valid", 32'(pos_out_valid_a), 32'd1);
        check("pos_token", 32'(pos_out_a), 32'd0);
        check("pos_pass_cnt", 32'(pass_cnt_a), 32'd1);
        check("pos_stall_cnt", stall_cnt_a, PERF ? 32'd1 : 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_valid", 32'(pos_out_valid_a), 32'd0);
        check("flush_pos_out", 32'(pos_out_a), 32'd0);
        check("flush_pass_cnt", 32'(pass_cnt_a), 32'd0);
        check("flush_final_sel", 32'(final_sel_a), 32'd0);
        check("flush_stall_cnt", stall_cnt_a, 32'd0);
        run_job('{2, 1, 1'b0, 2, 12, 2});

        // Table of whole loops.
        for (int i = 0; i < 9; i++) begin
            do_reset();
            run_job(jobs[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vr_pass_ctrl.md
# vr_pass_ctrl

Pass sequencer for the sparse vector-reduction loop: intersect unit (union mode), PE adder, and coord/val fiber_access buffers in loopback. It watches the upstream coordinate stream and the write-scanner input stream, and drives the shared read-scanner `us_pos_in` stream. Each loopback read of pass k is issued only after pass k-1 has been fully written. After the upstream done token it issues the final read-out with `final_sel` asserted.

## Interface
Parameters:
- `SLOTS`, 256: fiber slots in the buffet. Position wraps modulo SLOTS, which is a power of 2.
- `CNT_W`, 16: width of the pass and write counters.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `clk_en` in 1: 0 freezes all state.
- `flush` in 1: synchronous clear to IDLE.
- `tile_en` in 1: 0 holds the block in IDLE with `pos_out_valid`=0.
- `up_data` in 17: upstream coord token (monitor only).
- `up_valid` in 1, `up_ready` in 1: upstream handshake (monitor only).
- `wr_data` in 17: write-scanner data-in token (monitor only).
- `wr_valid` in 1, `wr_ready` in 1: write-scanner handshake (monitor only).
- `pos_out` out 17: token to read-scanner `us_pos_in`.
- `pos_out_valid` out 1, `pos_out_ready` in 1: handshake for `pos_out`.
- `final_sel` out 1: 1 routes read-scanner output to the final outputs instead of loopback.
- `pass_cnt` out CNT_W: passes issued.
- `stall_cnt` out 32: perf counter (see Configuration).

## Operation
Token encoding:
- bit16=0: data.
- 17'h10000: S0.
- 17'h10100: DONE.

Counters:
- `wr_cnt` increments on `wr_valid & wr_ready & wr_data==S0`.
- `p` (= `pass_cnt`) increments when a pass's S0 is accepted on `pos_out`.

States:
- **IDLE**: stays while `tile_en`=0, otherwise goes to DECIDE.
- **DECIDE**: requires `wr_cnt==p` and `up_valid`. It peeks at `up_data`; no upstream acceptance is required.
  - `up_data==DONE` → FIN_POS, or FIN_DONE if p==0.
  - Any other token → POS if p>0, STOP if p==0.
  - Otherwise it stays.
- **POS**: drives `pos_out` = {1'b0, (p-1) mod SLOTS} until accepted, then goes to STOP.
- **STOP**: drives S0 until accepted; then p++ and return to DECIDE.
- **FIN_POS**: drives the same position as POS until accepted, then FIN_STOP.
- **FIN_STOP**: drives S0 until accepted, then FIN_DONE.
- **FIN_DONE**: drives DONE until accepted, then END.
- **END**: holds with `pos_out_valid`=0 until `flush`.

Rules:
- `final_sel`=1 in FIN_POS, FIN_STOP, FIN_DONE and END; otherwise 0.
- Pass 0 reads an empty fiber: S0 only, no position.
- Counters wrap modulo 2^CNT_W. Comparisons are equality-only, so wrap-safe.
- `wr_cnt` may never exceed p. If `wr_cnt` would exceed p, it saturates at p (benches flag this as an error).

## Timing
- All outputs are registered.
- Reset and flush values: state IDLE, `pos_out`=0, `pos_out_valid`=0, `final_sel`=0, `pass_cnt`=0, `wr_cnt`=0, `stall_cnt`=0.
- DECIDE to first `pos_out_valid`: 1 cycle.
- With `pos_out_ready`=1 throughout, a pass costs 3 cycles: DECIDE, POS, STOP (2 for pass 0).
- `pos_out` and `pos_out_valid` hold stable until `pos_out_ready`. Valid never drops without acceptance.
- A write-monitor S0 accepted in the same cycle as DECIDE evaluation is counted before the next evaluation; it becomes visible in the following cycle.
- `flush` has priority over everything, including an in-flight handshake; the token is dropped.
- Async `rst_n` mid-pass aborts immediately.
- `clk_en`=0 freezes state and counters, and monitor events in that cycle are ignored. The upstream is clocked identically.
- `tile_en` falling mid-pass is ignored until END or flush. It is only sampled in IDLE.

## Configuration
- `VR_PASS_CTRL_PERF_EN`:
  - Defined: `stall_cnt` increments every cycle the block is in DECIDE with `up_valid`=1 and `wr_cnt!=p`. It saturates at 2^32-1.
  - Undefined: `stall_cnt` is tied to 0 and no counter logic is instantiated.

## Test plan
- Reset, `tile_en`=1, upstream presents DONE immediately → `pos_out` sequence is DONE only; `final_sel`=1 from cycle 2; `pass_cnt`=0.
- Three fibers then DONE, writes ack instantly, ready=1 → `pos_out` = S0; 0,S0; 1,S0; then 2,S0,DONE with `final_sel`=1; `pass_cnt`=3.
- Pass 1 requested while the write S0 of pass 0 is delayed 20 cycles → no `pos_out_valid` in that window; `stall_cnt`=20 with PERF_EN, 0 without.
- `pos_out_ready` toggled randomly (50%) → every token is held stable until accepted; the sequence is identical to the ready=1 case.
- SLOTS=4, six fibers then DONE → positions 0,1,2,3,0 issued for passes 1–5; final read position 1.
- `flush` asserted in POS with valid pending → next cycle IDLE, `pos_out_valid`=0, counters 0; re-run produces a correct sequence.
